// File: rtl/axi_read_responder.sv
// AXI4 read-only slave over a 64-bit synchronous memory.
// One burst at a time; beats flow through a 2-entry R FIFO.
module axi_read_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [ID_WIDTH-1:0]          ARID,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic [7:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [ID_WIDTH-1:0]          RID,
    output logic [63:0]                  RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic                         MemEn,
    output logic [$clog2(MEM_WORDS)-1:0] MemAddr,
    input  logic [63:0]                  MemRdData
);

    localparam int AW  = ADDR_WIDTH - 3;
    localparam int MAW = $clog2(MEM_WORDS);
    localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_WORDS);

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [63:0]         data;
        logic [1:0]          resp;
        logic                last;
    } beat_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [8:0]          total_q, total_d;
    logic [8:0]          issued_q, issued_d;
    logic                slv_q, slv_d;
    logic                fixed_q, fixed_d;
    logic                live_q;
    logic                infl_q;
    logic [1:0]          presp_q;
    logic                plast_q;
    beat_t               fifo_q [2];
    logic                wptr_q, rptr_q;
    logic [1:0]          cnt_q;

    logic                ar_hs, pop, issue, beat_ok, is_last;
    logic [1:0]          beat_resp;
    logic [63:0]         pdata;
    beat_t               head;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^ARADDR[2:0];

    assign head    = fifo_q[rptr_q];
    assign RVALID  = (cnt_q != 2'd0);
    assign RID     = RVALID ? head.id   : '0;
    assign RDATA   = RVALID ? head.data : '0;
    assign RRESP   = RVALID ? head.resp : '0;
    assign RLAST   = RVALID ? head.last : 1'b0;
    assign ARREADY = live_q && (state_q == IDLE);

    assign ar_hs     = ARVALID && ARREADY;
    assign pop       = RVALID && RREADY;
    assign beat_ok   = !slv_q && ({1'b0, addr_q} < MEM_LIM);
    assign beat_resp = slv_q ? 2'd2 : (beat_ok ? 2'd0 : 2'd3);
    assign is_last   = (issued_q == total_q - 9'd1);

    // A pop this cycle frees a slot, so credit it to keep 1 beat/cycle
    assign issue = (state_q == BURST) && (issued_q < total_q) &&
                   (({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));

    assign MemEn   = issue && beat_ok;
    assign MemAddr = MemEn ? addr_q[MAW-1:0] : '0;
    assign pdata   = (presp_q == 2'd0) ? MemRdData : 64'd0;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        total_d  = total_q;
        issued_d = issued_q;
        slv_d    = slv_q;
        fixed_d  = fixed_q;
        unique case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    id_d     = ARID;
                    addr_d   = ARADDR[ADDR_WIDTH-1:3];
                    total_d  = {1'b0, ARLEN} + 9'd1;
                    issued_d = 9'd0;
                    slv_d    = (ARSIZE != 3'd3) || ARBURST[1];
                    fixed_d  = (ARBURST == 2'd0);
                    state_d  = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    issued_d = issued_q + 9'd1;
                    if (!fixed_q) addr_d = addr_q + AW'(1);
                end
                if (pop && head.last) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            total_q  <= '0;
            issued_q <= '0;
            slv_q    <= 1'b0;
            fixed_q  <= 1'b0;
            live_q   <= 1'b0;
            infl_q   <= 1'b0;
            presp_q  <= '0;
            plast_q  <= 1'b0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            total_q  <= total_d;
            issued_q <= issued_d;
            slv_q    <= slv_d;
            fixed_q  <= fixed_d;
            live_q   <= 1'b1;
            infl_q   <= issue;
            if (issue) begin
                presp_q <= beat_resp;
                plast_q <= is_last;
            end
            wptr_q <= wptr_q ^ infl_q;
            rptr_q <= rptr_q ^ pop;
            cnt_q  <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset: outputs are masked while empty
    always_ff @(posedge ACLK) begin
        if (infl_q) fifo_q[wptr_q] <= {id_q, pdata, presp_q, plast_q};
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder with a mem[i]=i model.
module tb_axi_read_responder;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        MemEn;
    logic [9:0]  MemAddr;
    logic [63:0] MemRdData = '0;

    int compared = 0;
    int mismatched = 0;
    int memen_cnt = 0;
    int mark;
    logic tog = 1'b0;

    axi_read_responder #(
        .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_WORDS(1024)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .MemEn(MemEn), .MemAddr(MemAddr), .MemRdData(MemRdData)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (MemEn) begin
            MemRdData <= {54'd0, MemAddr};
            memen_cnt <= memen_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        ARID = id; ARADDR = addr; ARLEN = len;
        ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        @(negedge ACLK);
        chk("arready_before_hs", ARREADY, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    // Waits for one R handshake; waited = negedges seen including the hit
    task automatic beat(input string tag, input logic [3:0] eid,
                        input logic [63:0] ed, input logic [1:0] er,
                        input logic el, input int ewait);
        int waited;
        logic hit;
        waited = 0;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge ACLK);
            waited++;
            if (RVALID && RREADY) begin
                hit = 1'b1;
                chk({tag, "_rid"}, RID, eid);
                chk({tag, "_rdata"}, RDATA, ed);
                chk({tag, "_rresp"}, RRESP, er);
                chk({tag, "_rlast"}, RLAST, el);
                if (ewait > 0) chk({tag, "_latency"}, waited, ewait);
            end
            @(posedge ACLK); #1;
            if (tog) RREADY = ~RREADY;
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #12;
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_memen", MemEn, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // INCR 4 beats, RREADY high
        RREADY = 1'b1;
        send_ar(4'h5, 32'h40, 8'd3, 3'd3, 2'd1);
        beat("incr0", 4'h5, 64'd8, 2'd0, 1'b0, 3);
        beat("incr1", 4'h5, 64'd9, 2'd0, 1'b0, 1);
        beat("incr2", 4'h5, 64'd10, 2'd0, 1'b0, 1);
        beat("incr3", 4'h5, 64'd11, 2'd0, 1'b1, 1);
        @(negedge ACLK);
        chk("idle_arready", ARREADY, 1);
        chk("idle_rvalid", RVALID, 0);
        @(posedge ACLK); #1;

        // FIXED 3 beats
        send_ar(4'hA, 32'h40, 8'd2, 3'd3, 2'd0);
        beat("fix0", 4'hA, 64'd8, 2'd0, 1'b0, 3);
        beat("fix1", 4'hA, 64'd8, 2'd0, 1'b0, 1);
        beat("fix2", 4'hA, 64'd8, 2'd1 - 2'd1, 1'b1, 1);

        // Backpressure then toggling ready
        RREADY = 1'b0;
        mark = memen_cnt;
        send_ar(4'h3, 32'h40, 8'd7, 3'd3, 2'd1);
        repeat (10) begin
            @(posedge ACLK); #1;
        end
        @(negedge ACLK);
        chk("bp_memen_cnt", memen_cnt - mark, 2);
        chk("bp_rvalid", RVALID, 1);
        chk("bp_rdata_hold", RDATA, 8);
        chk("bp_arready", ARREADY, 0);
        @(posedge ACLK); #1;
        RREADY = 1'b1;
        tog = 1'b1;
        for (int k = 0; k < 8; k++)
            beat("tog", 4'h3, 64'(8 + k), 2'd0, (k == 7), 0);
        tog = 1'b0;
        RREADY = 1'b1;
        chk("tog_memen_cnt", memen_cnt - mark, 8);
        @(negedge ACLK);
        chk("tog_rvalid_after", RVALID, 0);
        @(posedge ACLK); #1;

        // Top of memory then out of range
        mark = memen_cnt;
        send_ar(4'h7, 32'h1FF8, 8'd1, 3'd3, 2'd1);
        beat("edge0", 4'h7, 64'd1023, 2'd0, 1'b0, 3);
        beat("edge1", 4'h7, 64'd0, 2'd3, 1'b1, 1);
        chk("edge_memen_cnt", memen_cnt - mark, 1);

        // WRAP -> whole burst SLVERR, no memory reads
        mark = memen_cnt;
        send_ar(4'h9, 32'h40, 8'd3, 3'd3, 2'd2);
        beat("wrap0", 4'h9, 64'd0, 2'd2, 1'b0, 3);
        beat("wrap1", 4'h9, 64'd0, 2'd2, 1'b0, 1);
        beat("wrap2", 4'h9, 64'd0, 2'd2, 1'b0, 1);
        beat("wrap3", 4'h9, 64'd0, 2'd2, 1'b1, 1);
        chk("wrap_memen_cnt", memen_cnt - mark, 0);

        // Narrow size -> SLVERR
        send_ar(4'h2, 32'h40, 8'd0, 3'd2, 2'd1);
        beat("size0", 4'h2, 64'd0, 2'd2, 1'b1, 3);

        // Reset mid-burst
        send_ar(4'hC, 32'h40, 8'd7, 3'd3, 2'd1);
        beat("pre0", 4'hC, 64'd8, 2'd0, 1'b0, 3);
        beat("pre1", 4'hC, 64'd9, 2'd0, 1'b0, 1);
        ARESETn = 1'b0;
        #2;
        chk("mid_rst_arready", ARREADY, 0);
        chk("mid_rst_rvalid", RVALID, 0);
        chk("mid_rst_rid", RID, 0);
        chk("mid_rst_rdata", RDATA, 0);
        chk("mid_rst_rresp", RRESP, 0);
        chk("mid_rst_rlast", RLAST, 0);
        chk("mid_rst_memen", MemEn, 0);
        chk("mid_rst_memaddr", MemAddr, 0);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("post_rst_arready", ARREADY, 1);
        chk("post_rst_rvalid", RVALID, 0);
        send_ar(4'h6, 32'h80, 8'd0, 3'd3, 2'd1);
        beat("post0", 4'h6, 64'd16, 2'd0, 1'b1, 3);
        @(negedge ACLK);
        chk("post_no_stale", RVALID, 0);
        chk("post_idle", ARREADY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
